round: RTL and testbench
========================

Name: round

Overview:
- One round of the PRESENT lightweight block cipher: 64-bit state, 80-bit key register.
- Computes addRoundKey, then sBoxLayer, then pLayer. Key schedule is out of scope; the caller supplies the current 80-bit key register each round.
- Result is registered with a single-cycle valid strobe so an iterative encryption controller can chain rounds.

Parameters:
- None. Widths are fixed by the cipher: state 64, key 80.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  x and k are valid this cycle; the round is computed and captured.
- x  input  64  round input state; bit 63 is the MSB.
- k  input  80  current key register; bit 79 is the MSB.
- r  output  64  registered round output state.
- out_valid  output  1  one-cycle pulse: r was updated on the preceding edge.

Behaviour:
- Reset (rst_n low, asynchronous): r = 64'h0 and out_valid = 0 immediately. Both hold while rst_n is low.
- Round function f(x,k), purely combinational:
  1. Round key: rk = k[79:16]. k[15:0] is ignored.
  2. AddRoundKey: s = x XOR rk.
  3. sBoxLayer: each of the 16 nibbles s[4i+3:4i] is replaced by S(nibble). S maps 0..F to C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2.
  4. pLayer: input bit i (i=0..62) moves to output bit (16*i) mod 63. Bit 63 stays at 63. Equivalently, bit i moves to 16*(i mod 4) + floor(i/4).
- Capture:
  - At a rising edge with in_valid=1: r <= f(x,k) and out_valid <= 1.
  - At a rising edge with in_valid=0: r holds its value and out_valid <= 0.
- Latency: exactly 1 cycle from in_valid to out_valid.
- Throughput: one round per cycle. Back-to-back in_valid is legal; out_valid then stays high and r updates every cycle.
- No backpressure. The consumer must sample r while out_valid=1, or before the next accepted in_valid.
- r is stable between accepted inputs. x and k are don't-care when in_valid=0.
- Reset asserted mid-operation: any pending result is discarded and r=0, out_valid=0.
- After reset release: the first edge with in_valid=1 produces valid output on the next cycle. No warm-up cycles.
- No X propagation from the unused bits k[15:0].
- Structure: S-box as a 16-entry case/ROM, instantiated 16 times. pLayer is pure wiring.

Test Plan:
- Reset: assert rst_n=0 with in_valid=1 and random x/k -> r=0000000000000000 and out_valid=0 immediately, without waiting for a clock edge.
- x=0000000000000000, k=00000000000000000000, in_valid pulse -> next cycle r=FFFFFFFF00000000, out_valid=1 for exactly one cycle.
- x=FFFFFFFFFFFFFFFF, k=0 -> r=00000000FFFF0000. Also x=0, k=FFFFFFFFFFFFFFFFFFFF -> r=00000000FFFF0000 (key XOR path).
- x=0000000000000001, k=0 -> r=FFFEFFFF00000001 (single-nibble S-box and pLayer mapping). Then x=0, k=0000000000000000FFFF -> r=FFFFFFFF00000000 (low 16 key bits ignored).
- Back-to-back: three consecutive in_valid cycles with the vectors above -> out_valid high for three cycles, and r matches each vector in order. Afterwards in_valid=0 -> r holds the last value and out_valid=0.
- Cross-check: x=D66E4DEF4CF03750, k=385594D326F713925305 -> r equals a software PRESENT-round model. Also compare 1000 random x/k pairs against the same model.

Source files
------------

// File: rtl/round.sv
// One PRESENT cipher round: addRoundKey, sBoxLayer, pLayer, with a registered result
// and a single-cycle valid strobe so a controller can iterate rounds back to back.
module round (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [63:0] x,
  input  logic [79:0] k,
  output logic [63:0] r,
  output logic        out_valid
);

  function automatic logic [3:0] sbox(input logic [3:0] n);
    logic [3:0] o;
    o = 4'h0;
    case (n)
      4'h0: o = 4'hC;
      4'h1: o = 4'h5;
      4'h2: o = 4'h6;
      4'h3: o = 4'hB;
      4'h4: o = 4'h9;
      4'h5: o = 4'h0;
      4'h6: o = 4'hA;
      4'h7: o = 4'hD;
      4'h8: o = 4'h3;
      4'h9: o = 4'hE;
      4'hA: o = 4'hF;
      4'hB: o = 4'h8;
      4'hC: o = 4'h4;
      4'hD: o = 4'h7;
      4'hE: o = 4'h1;
      4'hF: o = 4'h2;
      default: o = 4'h0;
    endcase
    return o;
  endfunction

  logic [63:0] s;
  logic [63:0] t;
  logic [63:0] p;
  logic [63:0] r_d, r_q;
  logic        valid_d, valid_q;

  // The round key is the top 64 bits of the key register; the low 16 only feed the schedule.
  logic unused_k;
  assign unused_k = ^k[15:0];

  assign s = x ^ k[79:16];

  for (genvar g = 0; g < 16; g++) begin : g_sbox
    assign t[4*g+3:4*g] = sbox(s[4*g+3:4*g]);
  end

  // Bit i lands at 16*(i mod 4) + i/4; bit 63 maps onto itself.
  for (genvar i = 0; i < 64; i++) begin : g_player
    assign p[16*(i%4) + i/4] = t[i];
  end

  always_comb begin
    r_d     = r_q;
    valid_d = 1'b0;
    if (in_valid) begin
      r_d     = p;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q     <= 64'h0;
      valid_q <= 1'b0;
    end else begin
      r_q     <= r_d;
      valid_q <= valid_d;
    end
  end

  assign r         = r_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_round.sv
// Directed and model-based check of one PRESENT round: reset, known vectors,
// back-to-back throughput, hold behaviour and random cross-check.
module tb_round;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [63:0] x;
  logic [79:0] k;
  logic [63:0] r;
  logic        out_valid;

  int unsigned n_vec;
  int unsigned n_err;

  round dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .x        (x),
    .k        (k),
    .r        (r),
    .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %016h, expected %016h", tag, got, exp);
    end
  endtask

  // Reference round using the (16*i) mod 63 form of the permutation.
  function automatic logic [63:0] model(input logic [63:0] xv, input logic [79:0] kv);
    logic [3:0]  sb [16];
    logic [63:0] st, sub, out;
    sb = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
           4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
    st = xv ^ kv[79:16];
    for (int n = 0; n < 16; n++) sub[4*n +: 4] = sb[st[4*n +: 4]];
    out = 64'h0;
    for (int i = 0; i < 63; i++) out[(16*i) % 63] = sub[i];
    out[63] = sub[63];
    return out;
  endfunction

  function automatic logic [79:0] rand_key();
    return {$urandom(), $urandom(), 16'($urandom())};
  endfunction

  function automatic logic [63:0] rand_state();
    return {$urandom(), $urandom()};
  endfunction

  // One isolated transaction: present at a falling edge, inspect one and two cycles later.
  task automatic single(input string tag, input logic [63:0] xv, input logic [79:0] kv,
                        input logic [63:0] exp);
    @(negedge clk);
    in_valid = 1'b1;
    x        = xv;
    k        = kv;
    @(negedge clk);
    in_valid = 1'b0;
    x        = rand_state();
    k        = rand_key();
    check({tag, ".r"}, r, exp);
    check({tag, ".ov"}, 64'(out_valid), 64'd1);
    @(negedge clk);
    check({tag, ".ov_drop"}, 64'(out_valid), 64'd0);
    check({tag, ".r_hold"}, r, exp);
  endtask

  logic [63:0] exp_prev;
  logic [63:0] xr;
  logic [79:0] kr;

  initial begin
    n_vec    = 0;
    n_err    = 0;
    rst_n    = 1'b0;
    in_valid = 1'b1;
    x        = rand_state();
    k        = rand_key();
    #1;
    check("reset_r", r, 64'h0);
    check("reset_ov", 64'(out_valid), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold_r", r, 64'h0);
    check("reset_hold_ov", 64'(out_valid), 64'd0);

    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;

    single("zero", 64'h0, 80'h0, 64'hFFFFFFFF00000000);
    single("x_ones", 64'hFFFFFFFFFFFFFFFF, 80'h0, 64'h00000000FFFF0000);
    single("k_ones", 64'h0, 80'hFFFFFFFFFFFFFFFFFFFF, 64'h00000000FFFF0000);
    single("x_one", 64'h1, 80'h0, 64'hFFFEFFFF00000001);
    single("k_low", 64'h0, 80'h0000000000000000FFFF, 64'hFFFFFFFF00000000);

    // Back-to-back: three consecutive accepted inputs.
    @(negedge clk);
    in_valid = 1'b1; x = 64'hFFFFFFFFFFFFFFFF; k = 80'h0;
    @(negedge clk);
    check("b2b0.r", r, 64'h00000000FFFF0000);
    check("b2b0.ov", 64'(out_valid), 64'd1);
    x = 64'h1; k = 80'h0;
    @(negedge clk);
    check("b2b1.r", r, 64'hFFFEFFFF00000001);
    check("b2b1.ov", 64'(out_valid), 64'd1);
    x = 64'h0; k = 80'h0000000000000000FFFF;
    @(negedge clk);
    check("b2b2.r", r, 64'hFFFFFFFF00000000);
    check("b2b2.ov", 64'(out_valid), 64'd1);
    in_valid = 1'b0; x = rand_state(); k = rand_key();
    repeat (2) @(negedge clk);
    check("b2b_hold.r", r, 64'hFFFFFFFF00000000);
    check("b2b_hold.ov", 64'(out_valid), 64'd0);

    single("xcheck", 64'hD66E4DEF4CF03750, 80'h385594D326F713925305,
           model(64'hD66E4DEF4CF03750, 80'h385594D326F713925305));

    // Random cross-check, streamed one per cycle.
    @(negedge clk);
    xr = rand_state(); kr = rand_key();
    in_valid = 1'b1; x = xr; k = kr;
    exp_prev = model(xr, kr);
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      check("rand.r", r, exp_prev);
      xr = rand_state(); kr = rand_key();
      x = xr; k = kr;
      exp_prev = model(xr, kr);
    end
    @(negedge clk);
    check("rand_last.r", r, exp_prev);
    check("rand_last.ov", 64'(out_valid), 64'd1);

    // Reset asserted mid-stream, away from any clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_r", r, 64'h0);
    check("midrst_ov", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    check("midrst_hold_r", r, 64'h0);
    check("midrst_hold_ov", 64'(out_valid), 64'd0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(negedge clk);
    check("post_rst_idle_ov", 64'(out_valid), 64'd0);
    single("post_rst", 64'h0, 80'h0, 64'hFFFFFFFF00000000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
